// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The line is brought into the clock domain through a two-flop synchronizer.
// A start edge is detected in IDLE, and the start bit is re-checked at
// mid-bit. Eight data bits are then sampled LSB first, one bit period apart,
// followed by the stop bit. A good stop bit updates rx_data with a one-cycle
// rx_valid pulse. A low stop bit gives a one-cycle frame_err pulse instead.
//
// Handshake: rx_valid and frame_err are single-cycle, mutually exclusive
// strobes with no back-pressure. rx_data is valid while rx_valid is high and
// holds its value until the next good byte arrives.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    // Terminal counts. The counter is cleared on the edge where it matches
    // one of these values, so each period is exactly N cycles long.
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    logic        sync_meta;
    logic        rx_sync;
    logic        rx_prev;

    // Synchronize rx. All three flops are preset high so that reset cannot
    // create a false falling edge on an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
        end else begin
            sync_meta <= rx;
            rx_sync   <= sync_meta;
            rx_prev   <= rx_sync;
        end
    end

    // Receive FSM: bit timing, sampling, byte assembly and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            // Strobes last one cycle unless the stop evaluation re-asserts one.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    count   <= 16'd0;
                    bit_idx <= 3'd0;
                    // Only a real 1->0 transition starts a frame. A line held
                    // low (break) therefore cannot retrigger.
                    if (rx_prev && !rx_sync) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (count == HALF_LAST) begin
                        count <= 16'd0;
                        if (!rx_sync) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // The line was already high again at mid-start:
                            // treat it as a glitch and drop it silently.
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                DATA: begin
                    if (count == BIT_LAST) begin
                        count          <= 16'd0;
                        shift[bit_idx] <= rx_sync;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                STOP: begin
                    if (count == BIT_LAST) begin
                        count   <= 16'd0;
                        // Leave at mid-stop so that a start bit arriving right
                        // after the stop bit is still seen as a falling edge.
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (rx_sync) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    count   <= 16'd0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus for uart_rx, checked by a scoreboard.
// Bit time is shortened so that the whole run stays short.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // From the cycle count when the start bit is driven to the cycle in which
    // the strobe is visible: 2 synchronizer edges, the detection edge, half a
    // bit to mid-start, then 8 data bits and the stop bit at full bit spacing.
    localparam int LATENCY = 3 + HALF + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int vectors;
    int miscompares;
    int cyc;

    // Expected strobes. bit 8: 1 = frame_err, 0 = rx_valid. bits 7:0 = rx_data.
    logic [8:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [7:0] last_good;

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver tasks. Each one is entered and left on a negedge.
    task automatic drive_bit(input logic value);
        rx = value;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a well-framed byte updates the last good value. A bad
    // stop bit reports an error and leaves the last good value as it was.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        if (stop_bit) begin
            last_good = data;
            exp_q.push_back({1'b0, data});
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        exp_cyc_q.push_back(cyc + LATENCY);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_rx_busy"}, rx_busy, 1'b0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the expected queue in kind,
    // data and cycle. An expected strobe that never appears times out here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && frame_err) begin
                check("both_strobes", 1, 0);
            end
            if (rx_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: rx_valid=%0b frame_err=%0b rx_data=%0h, none expected (cycle %0d)",
                             rx_valid, frame_err, rx_data, cyc);
                end else begin
                    logic [8:0] e;
                    int         t;
                    e = exp_q.pop_front();
                    t = exp_cyc_q.pop_front();
                    check("strobe_kind_frame_err", frame_err, e[8]);
                    check("strobe_time", cyc, t);
                    check("strobe_rx_data", rx_data, e[7:0]);
                end
            end else if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_strobe: no strobe, expected kind=%0b data=%0h at cycle %0d (now %0d)",
                         exp_q[0][8], exp_q[0][7:0], exp_cyc_q[0], cyc);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_good   = 8'h00;
        rst_n       = 1'b1;
        rx          = 1'b1;

        // Reset applied mid-cycle clears the outputs at once; idle line stays quiet.
        repeat (2) @(negedge clk);
        async_reset_check("reset");
        idle(200);
        check("idle_rx_busy", rx_busy, 1'b0);
        check("idle_rx_data", rx_data, 8'h00);

        // Single byte.
        send_frame(8'hA5, 1'b1);
        idle(10);
        wait_drain(400);
        check("single_rx_data", rx_data, 8'hA5);

        // Glitch shorter than half a bit is rejected, then a real frame follows.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", rx_busy, 1'b1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_low", rx_busy, 1'b0);
        send_frame(8'h3C, 1'b1);
        idle(10);
        wait_drain(400);

        // Framing error, then a long break that must not produce more strobes.
        send_frame(8'h5A, 1'b0);
        rx = 1'b0;
        repeat (600) @(negedge clk);
        check("break_busy_low", rx_busy, 1'b0);
        check("break_rx_data", rx_data, 8'h3C);
        idle(20);
        wait_drain(400);

        // Back-to-back frames with no idle time between them.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(10);
        wait_drain(400);
        check("b2b_rx_data", rx_data, 8'h81);

        // Randomized frames with random gaps and occasional bad stop bits.
        for (int i = 0; i < 25; i++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, s);
            if (s) idle($urandom_range(0, 2 * CPB));
            else   idle($urandom_range(2, 2 * CPB));
        end
        idle(10);
        wait_drain(400);
        check("random_last_good", rx_data, last_good);

        // Reset partway through bit 4 of 0xC3: the partial byte is discarded.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
        rx = 1'b0;
        repeat (HALF) @(negedge clk);
        async_reset_check("midframe");
        idle(300);
        check("midframe_rx_data", rx_data, 8'h00);
        send_frame(8'h7E, 1'b1);
        idle(10);
        wait_drain(400);
        check("final_rx_data", rx_data, 8'h7E);
        check("final_rx_busy", rx_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
